// File: rtl/noc_cmd_pkg.sv
// rtl/noc_cmd_pkg.sv - shared opcodes, ack codes and assembly states for the NoC command decoder
package noc_cmd_pkg;

  localparam logic [7:0] NOC_OP_WRITE = 8'h02;
  localparam logic [7:0] NOC_OP_READ  = 8'h03;
  localparam logic [7:0] NOC_OP_SE4K  = 8'h20;
  localparam logic [7:0] NOC_OP_BE32K = 8'h52;
  localparam logic [7:0] NOC_OP_BE64K = 8'hD8;
  localparam logic [7:0] NOC_OP_RESET = 8'h99;

  localparam logic [3:0] FSM_OP_NONE  = 4'd0;
  localparam logic [3:0] FSM_OP_WRITE = 4'd1;
  localparam logic [3:0] FSM_OP_READ  = 4'd2;
  localparam logic [3:0] FSM_OP_SE4K  = 4'd3;
  localparam logic [3:0] FSM_OP_BE32K = 4'd4;
  localparam logic [3:0] FSM_OP_BE64K = 4'd5;
  localparam logic [3:0] FSM_OP_RESET = 4'd6;

  localparam logic [1:0] ACK_OK      = 2'b00;
  localparam logic [1:0] ACK_ILLEGAL = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_ADDR, S_PUSH} state_t;

  // Unknown NoC opcodes map to FSM_OP_NONE, which marks the frame as illegal.
  function automatic logic [3:0] decode_op(input logic [7:0] b);
    case (b)
      NOC_OP_WRITE: decode_op = FSM_OP_WRITE;
      NOC_OP_READ:  decode_op = FSM_OP_READ;
      NOC_OP_SE4K:  decode_op = FSM_OP_SE4K;
      NOC_OP_BE32K: decode_op = FSM_OP_BE32K;
      NOC_OP_BE64K: decode_op = FSM_OP_BE64K;
      NOC_OP_RESET: decode_op = FSM_OP_RESET;
      default:      decode_op = FSM_OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/noc_cmd_fifo.sv
// rtl/noc_cmd_fifo.sv - synchronous command queue with full/empty flags
module noc_cmd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [PW:0]      count_q;
  logic             wr, rd;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  // A pop in the same cycle frees the slot, so a full queue still accepts the push.
  assign wr      = push_i && (!full_o || pop_i);
  assign rd      = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr) wptr_q <= wptr_q + 1'b1;
      if (rd) rptr_q <= rptr_q + 1'b1;
      case ({wr, rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/noc_cmd_decoder.sv
// rtl/noc_cmd_decoder.sv - assembles NoC command frames, queues them and issues them to the flash FSM
module noc_cmd_decoder
  import noc_cmd_pkg::*;
#(
  parameter int ADDR_BYTES = 3,
  parameter int DEPTH      = 4,
  parameter int LEN_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    noc_valid,
  input  logic [7:0]              noc_data,
  output logic                    noc_ready,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [3:0]              fsm_opcode,
  output logic                    read_write,
  output logic [LEN_W-1:0]        transaction_length,
  output logic [8*ADDR_BYTES-1:0] address,
  input  logic                    transaction_done,
  output logic                    ack_valid,
  output logic [1:0]              ack_status
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int EW = 4 + 1 + LEN_W + AW;
  localparam int CW = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       op_q;
  logic             rw_q;
  logic [LEN_W-1:0] len_q;
  logic [AW-1:0]    addr_q;
  logic             drop_q;
  logic             busy_q, pend_q, ack_valid_q;
  logic [1:0]       ack_status_q;

  logic             accept, last_addr, ill_evt, done_evt, pop, push, full, empty;
  logic [EW-1:0]    head;
  logic [3:0]       head_op;
  logic             head_rw;
  logic [LEN_W-1:0] head_len;
  logic [AW-1:0]    head_addr;

  assign noc_ready = (state_q != S_PUSH);
  assign accept    = noc_valid && noc_ready;
  assign last_addr = (cnt_q == CW'(ADDR_BYTES - 1));
  // Zero-length read/write frames are rejected on their final byte, after the whole frame is consumed.
  assign ill_evt   = accept && (((state_q == S_IDLE) && (decode_op(noc_data) == FSM_OP_NONE)) ||
                                ((state_q == S_ADDR) && last_addr && drop_q));
  assign done_evt  = transaction_done && busy_q;
  assign cmd_valid = !empty && !busy_q;
  assign pop       = cmd_valid && cmd_ready;
  assign push      = (state_q == S_PUSH) && !drop_q;

  noc_cmd_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i ({op_q, rw_q, len_q, addr_q}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign {head_op, head_rw, head_len, head_addr} = head;
  assign fsm_opcode         = cmd_valid ? head_op   : '0;
  assign read_write         = cmd_valid ? head_rw   : 1'b0;
  assign transaction_length = cmd_valid ? head_len  : '0;
  assign address            = cmd_valid ? head_addr : '0;
  assign ack_valid          = ack_valid_q;
  assign ack_status         = ack_status_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= FSM_OP_NONE;
      rw_q    <= 1'b0;
      len_q   <= '0;
      addr_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          op_q   <= decode_op(noc_data);
          rw_q   <= (noc_data == NOC_OP_WRITE);
          len_q  <= '0;
          addr_q <= '0;
          drop_q <= 1'b0;
          cnt_q  <= '0;
          case (decode_op(noc_data))
            FSM_OP_WRITE, FSM_OP_READ:              state_q <= S_LEN;
            FSM_OP_SE4K, FSM_OP_BE32K, FSM_OP_BE64K: state_q <= S_ADDR;
            FSM_OP_RESET:                           state_q <= S_PUSH;
            default:                                state_q <= S_IDLE;
          endcase
        end
        S_LEN: if (accept) begin
          len_q   <= noc_data[LEN_W-1:0];
          drop_q  <= (noc_data == 8'h00);
          state_q <= S_ADDR;
        end
        S_ADDR: if (accept) begin
          addr_q <= AW'({addr_q, noc_data});
          if (last_addr) begin
            cnt_q   <= '0;
            state_q <= S_PUSH;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_PUSH: if (drop_q || !full || pop) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // A done ack always wins; a colliding illegal ack waits one cycle in pend_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= 1'b0;
      pend_q       <= 1'b0;
      ack_valid_q  <= 1'b0;
      ack_status_q <= ACK_OK;
    end else begin
      if (pop)           busy_q <= 1'b1;
      else if (done_evt) busy_q <= 1'b0;
      if (done_evt) begin
        ack_valid_q  <= 1'b1;
        ack_status_q <= ACK_OK;
        pend_q       <= pend_q || ill_evt;
      end else if (pend_q) begin
        ack_valid_q  <= 1'b1;
        ack_status_q <= ACK_ILLEGAL;
        pend_q       <= ill_evt;
      end else if (ill_evt) begin
        ack_valid_q  <= 1'b1;
        ack_status_q <= ACK_ILLEGAL;
      end else begin
        ack_valid_q  <= 1'b0;
        ack_status_q <= ACK_OK;
      end
    end
  end

endmodule

// File: tb/tb_noc_cmd_decoder.sv
// tb/tb_noc_cmd_decoder.sv - directed self-checking bench for noc_cmd_decoder
module tb_noc_cmd_decoder;

  localparam int ADDR_BYTES = 3;
  localparam int DEPTH      = 4;
  localparam int LEN_W      = 4;
  localparam int AW         = 8 * ADDR_BYTES;

  logic             clk = 1'b0;
  logic             rst, noc_valid, noc_ready, cmd_valid, cmd_ready;
  logic [7:0]       noc_data;
  logic [3:0]       fsm_opcode;
  logic             read_write, transaction_done, ack_valid;
  logic [LEN_W-1:0] transaction_length;
  logic [AW-1:0]    address;
  logic [1:0]       ack_status;

  int errors = 0;
  int checks = 0;

  noc_cmd_decoder #(.ADDR_BYTES(ADDR_BYTES), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .noc_valid          (noc_valid),
    .noc_data           (noc_data),
    .noc_ready          (noc_ready),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .fsm_opcode         (fsm_opcode),
    .read_write         (read_write),
    .transaction_length (transaction_length),
    .address            (address),
    .transaction_done   (transaction_done),
    .ack_valid          (ack_valid),
    .ack_status         (ack_status)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    noc_valid = 1'b1;
    noc_data  = b;
    while (noc_ready !== 1'b1 && guard < 50) begin
      step();
      guard++;
    end
    checks++;
    if (noc_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout: noc_ready=%b required=1", noc_ready);
    end
    step();
    noc_valid = 1'b0;
    noc_data  = 8'h00;
  endtask

  task automatic drain_one(input logic [3:0] exp_op);
    checks++;
    if (cmd_valid !== 1'b1 || fsm_opcode !== exp_op) begin
      errors++;
      $display("FAIL drain_head: cmd_valid=%b op=%0d required valid=1 op=%0d", cmd_valid, fsm_opcode, exp_op);
    end
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    transaction_done = 1'b1;
    step();
    transaction_done = 1'b0;
    checks++;
    if (ack_valid !== 1'b1 || ack_status !== 2'b00) begin
      errors++;
      $display("FAIL drain_ack: ack_valid=%b status=%b required 1/00", ack_valid, ack_status);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({noc_ready, cmd_valid, ack_valid, ack_status, fsm_opcode, read_write, transaction_length, address} !==
        {1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 1'b0, {LEN_W{1'b0}}, {AW{1'b0}}}) begin
      errors++;
      $display("FAIL %s: rdy=%b cv=%b av=%b st=%b op=%0d rw=%b len=%0d addr=%h required 1/0/0/00/0/0/0/0",
               name, noc_ready, cmd_valid, ack_valid, ack_status, fsm_opcode, read_write, transaction_length, address);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_idle_outputs("reset_values");
  endtask

  task automatic test_read();
    send_byte(8'h03); send_byte(8'h05); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    checks++;
    if (cmd_valid !== 1'b0 || noc_ready !== 1'b0) begin
      errors++;
      $display("FAIL read_push_cycle: cmd_valid=%b noc_ready=%b required 0/0", cmd_valid, noc_ready);
    end
    step();
    checks++;
    if (cmd_valid !== 1'b1 || fsm_opcode !== 4'd2 || read_write !== 1'b0 ||
        transaction_length !== 4'd5 || address !== 24'h123456) begin
      errors++;
      $display("FAIL read_decode: cv=%b op=%0d rw=%b len=%0d addr=%h required 1/2/0/5/123456",
               cmd_valid, fsm_opcode, read_write, transaction_length, address);
    end
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_busy: cmd_valid=%b required 0", cmd_valid);
    end
    transaction_done = 1'b1;
    step();
    transaction_done = 1'b0;
    checks++;
    if (ack_valid !== 1'b1 || ack_status !== 2'b00) begin
      errors++;
      $display("FAIL read_ack: ack_valid=%b status=%b required 1/00", ack_valid, ack_status);
    end
    step();
    checks++;
    if (ack_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_ack_pulse: ack_valid=%b required 0", ack_valid);
    end
  endtask

  task automatic test_illegal();
    send_byte(8'h7E);
    checks++;
    if (ack_valid !== 1'b1 || ack_status !== 2'b10 || cmd_valid !== 1'b0 || noc_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_ack: av=%b st=%b cv=%b rdy=%b required 1/10/0/1", ack_valid, ack_status, cmd_valid, noc_ready);
    end
    send_byte(8'h99);
    step();
    checks++;
    if (cmd_valid !== 1'b1 || fsm_opcode !== 4'd6 || transaction_length !== 4'd0 || address !== 24'h0) begin
      errors++;
      $display("FAIL illegal_next_frame: cv=%b op=%0d len=%0d addr=%h required 1/6/0/000000",
               cmd_valid, fsm_opcode, transaction_length, address);
    end
    drain_one(4'd6);
  endtask

  task automatic test_write();
    send_byte(8'h02); send_byte(8'h03); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hEF);
    step();
    checks++;
    if (cmd_valid !== 1'b1 || fsm_opcode !== 4'd1 || read_write !== 1'b1 ||
        transaction_length !== 4'd3 || address !== 24'hABCDEF) begin
      errors++;
      $display("FAIL write_decode: cv=%b op=%0d rw=%b len=%0d addr=%h required 1/1/1/3/abcdef",
               cmd_valid, fsm_opcode, read_write, transaction_length, address);
    end
    drain_one(4'd1);
  endtask

  task automatic test_len_zero();
    int seen = 0;
    logic [1:0] st = 2'b00;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    for (int i = 0; i < 4; i++) begin
      if (ack_valid === 1'b1) begin
        seen++;
        st = ack_status;
      end
      checks++;
      if (cmd_valid !== 1'b0) begin
        errors++;
        $display("FAIL len_zero_queued: cmd_valid=%b required 0 (cycle %0d)", cmd_valid, i);
      end
      step();
    end
    checks++;
    if (seen != 1 || st !== 2'b10) begin
      errors++;
      $display("FAIL len_zero_ack: acks=%0d status=%b required 1/10", seen, st);
    end
    checks++;
    if (noc_ready !== 1'b1) begin
      errors++;
      $display("FAIL len_zero_ready: noc_ready=%b required 1", noc_ready);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    for (int i = 0; i < 5; i++) send_byte(8'h99);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (noc_ready !== 1'b0 || cmd_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_full_stall: noc_ready=%b cmd_valid=%b required 0/1", noc_ready, cmd_valid);
      end
      step();
    end
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    checks++;
    if (noc_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_release: noc_ready=%b required 1", noc_ready);
    end
    transaction_done = 1'b1;
    step();
    transaction_done = 1'b0;
    while (cmd_valid === 1'b1 && n < 8) begin
      drain_one(4'd6);
      n++;
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL b2b_remaining: entries=%0d required 4", n);
    end
  endtask

  task automatic test_ack_collision();
    send_byte(8'h99);
    step();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    noc_valid = 1'b1;
    noc_data  = 8'h7E;
    transaction_done = 1'b1;
    step();
    noc_valid = 1'b0;
    transaction_done = 1'b0;
    checks++;
    if (ack_valid !== 1'b1 || ack_status !== 2'b00) begin
      errors++;
      $display("FAIL collide_first: ack_valid=%b status=%b required 1/00", ack_valid, ack_status);
    end
    step();
    checks++;
    if (ack_valid !== 1'b1 || ack_status !== 2'b10) begin
      errors++;
      $display("FAIL collide_second: ack_valid=%b status=%b required 1/10", ack_valid, ack_status);
    end
    step();
    checks++;
    if (ack_valid !== 1'b0) begin
      errors++;
      $display("FAIL collide_end: ack_valid=%b required 0", ack_valid);
    end
  endtask

  task automatic test_reset_mid();
    send_byte(8'h99);
    step();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    send_byte(8'h99);
    send_byte(8'h20); send_byte(8'h00); send_byte(8'h10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle_outputs("mid_reset_values");
    transaction_done = 1'b1;
    step();
    transaction_done = 1'b0;
    checks++;
    if (ack_valid !== 1'b0 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_flush: ack_valid=%b cmd_valid=%b required 0/0", ack_valid, cmd_valid);
    end
    send_byte(8'hD8); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    step();
    checks++;
    if (cmd_valid !== 1'b1 || fsm_opcode !== 4'd5 || read_write !== 1'b0 ||
        transaction_length !== 4'd0 || address !== 24'h001000) begin
      errors++;
      $display("FAIL mid_reset_next: cv=%b op=%0d rw=%b len=%0d addr=%h required 1/5/0/0/001000",
               cmd_valid, fsm_opcode, read_write, transaction_length, address);
    end
    drain_one(4'd5);
  endtask

  initial begin
    rst = 1'b1;
    noc_valid = 1'b0;
    noc_data = 8'h00;
    cmd_ready = 1'b0;
    transaction_done = 1'b0;
    test_reset();
    test_read();
    test_illegal();
    test_write();
    test_len_zero();
    test_back_to_back();
    test_ack_collision();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/noc_cmd_decoder.md
# noc_cmd_decoder

Parametrised NoC command front end for the SPI flash memory interface. It accepts byte-serial command frames from the NoC, decodes the flash opcode, and assembles the optional length and address fields. Decoded commands go into a DEPTH-entry queue, which issues them one at a time to the flash FSM. The block returns one acknowledgement per frame: on `transaction_done`, or immediately for a rejected frame.

## Interface
- `ADDR_BYTES`, 3: address bytes per frame, MSB first. Address width AW = 8*ADDR_BYTES.
- `DEPTH`, 4: command queue depth, power of two, ≥2.
- `LEN_W`, 4: width of `transaction_length`, ≤8.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `noc_valid` in 1: NoC byte valid.
- `noc_data` in 8: NoC byte.
- `noc_ready` out 1: byte accepted when `noc_valid && noc_ready`.
- `cmd_valid` out 1: decoded command available to flash FSM.
- `cmd_ready` in 1: flash FSM takes command on `cmd_valid && cmd_ready`.
- `fsm_opcode` out 4: internal opcode.
- `read_write` out 1: 1 = write, 0 = read/other.
- `transaction_length` out LEN_W: byte count.
- `address` out AW: flash address.
- `transaction_done` in 1: one-cycle pulse when the issued command completes.
- `ack_valid` out 1: one-cycle acknowledgement pulse.
- `ack_status` out 2: 00 = OK, 10 = ILLEGAL.

## Operation
- Frame = opcode byte, then fields by opcode:
  - 0x02 write: fsm_opcode 1, rw=1. Fields: length byte, then address.
  - 0x03 read: fsm_opcode 2, rw=0. Fields: length byte, then address.
  - 0x20 sector erase 4 KiB: fsm_opcode 3. Address only.
  - 0x52 block erase 32 KiB: fsm_opcode 4. Address only.
  - 0xD8 block erase 64 KiB: fsm_opcode 5. Address only.
  - 0x99 reset: fsm_opcode 6. No fields.
  - For every opcode without a length field, length = 0 and rw = 0.
- Any other opcode:
  - The frame ends after the opcode byte.
  - Nothing is queued; an ILLEGAL ack is generated.
- Read/write with length byte 0:
  - The full frame is consumed, but not queued; an ILLEGAL ack is generated.
  - Otherwise `transaction_length` = length[LEN_W-1:0].
- Assembly FSM:
  - IDLE → LEN (read/write) | ADDR (erase) | PUSH (reset) | IDLE (illegal).
  - LEN → ADDR.
  - ADDR → PUSH after ADDR_BYTES bytes; a byte counter counts up to ADDR_BYTES-1.
  - PUSH → IDLE once the entry is written or dropped.
  - States advance only on accepted bytes. `noc_ready` = 0 in PUSH, 1 elsewhere.
  - PUSH waits while the queue is full, holding the entry and keeping `noc_ready` low.
- Issue:
  - `cmd_valid` = queue not empty AND NOT busy.
  - On the handshake: pop the head and set busy.
  - `transaction_done` clears busy and produces an OK ack.
  - `transaction_done` while not busy is ignored.
- Ack arbitration: a done ack and an illegal ack in the same cycle → the done ack goes first. The illegal ack is held in a pending flag and issued the next cycle. At most one pending.
- Reset: all state is flushed. This includes a mid-frame partial assembly, queue contents and busy. A completion after reset produces no ack.

## Timing
- Reset values:
  - `noc_ready`=1, `cmd_valid`=0, `ack_valid`=0, `ack_status`=00.
  - `fsm_opcode`=0, `read_write`=0, `transaction_length`=0, `address`=0.
- Entry write:
  - The last byte of a frame is accepted at edge E.
  - PUSH is the cycle after E; the entry is written at edge E+1.
  - `cmd_valid` rises in the cycle after E+1 if the queue was empty and not busy. Accepted-to-issue latency is 2 cycles.
- Command outputs come from the queue head; they are stable while `cmd_valid` is high and `cmd_ready` is low.
- Acks:
  - `ack_valid` is registered, one cycle after `transaction_done`.
  - An illegal ack fires one cycle after the rejecting byte is accepted, subject to arbitration.
- Throughput: a reset frame takes 2 cycles per frame (opcode plus PUSH). The NoC is never stalled except in PUSH.
- Simultaneous push and pop on the queue are both honoured, including when full. The queue pointers wrap modulo DEPTH.

## Structure
- Package `noc_cmd_pkg` holds:
  - NoC opcode constants (0x02, 0x03, 0x20, 0x52, 0xD8, 0x99).
  - fsm_opcode constants 1–6.
  - Ack status constants.
  - FSM state encoding.
- Sub-module `noc_cmd_fifo`: synchronous FIFO, parametrised WIDTH/DEPTH, with full/empty flags. Entry = {fsm_opcode, read_write, length, address}.

## Test plan
- Read frame (ADDR_BYTES=3) 03,05,12,34,56 → one `cmd_valid` with opcode 2, rw 0, len 5, addr 0x123456. After `transaction_done`, `ack_valid` with status 00 one cycle later.
- Frame byte 0x7E → no `cmd_valid`. `ack_valid` with status 10 one cycle after acceptance. The next frame, 99, queues opcode 6.
- Five back-to-back 0x99 frames with `cmd_ready` = 0 (DEPTH=4) → 4 queued. `noc_ready` stays low in PUSH until the first pop, then the fifth entry is written.
- Write frame 02,00,… with length 0 → all 5 bytes consumed, nothing queued, ILLEGAL ack.
- An illegal ack coincides with a `transaction_done` → OK ack in cycle N, ILLEGAL ack in cycle N+1.
- `rst` asserted after the 3rd byte of an erase frame → outputs return to reset values, queue empty. The next frame D8,00,10,00 decodes cleanly (opcode 5, addr 0x001000).
